// File: rtl/pwm_audio_monitor_if.sv
// Record stream from the PWM duty-cycle monitor: first-word fall-through valid/ready.
// The monitor drives the master side; the consumer drives out_ready.
interface pwm_audio_monitor_if #(
    parameter int CH_W     = 1,
    parameter int SAMPLE_W = 9
);
    logic                out_valid;
    logic                out_ready;
    logic [CH_W-1:0]     out_ch;
    logic [SAMPLE_W-1:0] out_sample;

    modport master (
        output out_valid,
        output out_ch,
        output out_sample,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_ch,
        input  out_sample,
        output out_ready
    );
endinterface

// File: rtl/pwm_audio_monitor.sv
// Multi-channel PWM duty-cycle monitor: counts high cycles per channel over fixed
// 2^WINDOW_LOG2-clock windows and queues one {channel, count} record per enabled channel.
module pwm_audio_monitor #(
    parameter int NUM_CH      = 2,
    parameter int WINDOW_LOG2 = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int SAMPLE_W    = WINDOW_LOG2 + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NUM_CH-1:0] pwm_in,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              overflow,
    pwm_audio_monitor_if.master out_if
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_t;

    state_t                  r_state;
    logic [WINDOW_LOG2-1:0]  r_cnt;
    logic [NUM_CH-1:0]       r_mask;
    logic [SAMPLE_W-1:0]     r_acc  [NUM_CH];
    logic [SAMPLE_W-1:0]     r_snap [NUM_CH];
    logic [NUM_CH-1:0]       r_pend;
    logic                    r_push_vld;
    logic [CH_W-1:0]         r_push_ch;
    logic [SAMPLE_W-1:0]     r_push_smp;
    logic [CH_W-1:0]         r_mem_ch  [FIFO_DEPTH];
    logic [SAMPLE_W-1:0]     r_mem_smp [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic                    r_overflow;

    logic                    w_busy;
    logic                    w_accept_start;
    logic                    w_stop_now;
    logic                    w_count_en;
    logic                    w_win_end;
    logic [NUM_CH-1:0][SAMPLE_W-1:0] w_acc_inc;
    logic [NUM_CH-1:0]       w_low;
    logic [CH_W-1:0]         w_sel_idx;
    logic                    w_sel_hit;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_valid;

    // Pending serializer work keeps busy high even after stop returns the FSM to idle.
    assign w_busy         = (r_state == ST_MEASURE) || (|r_pend) || r_push_vld;
    assign w_accept_start = (r_state == ST_IDLE) && start && !w_busy;
    assign w_stop_now     = (r_state == ST_MEASURE) && stop;
    assign w_count_en     = (r_state == ST_MEASURE) && !stop && ena;
    assign w_win_end      = w_count_en && (&r_cnt);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_inc
            assign w_acc_inc[gi] = r_acc[gi] + SAMPLE_W'(pwm_in[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_start) begin
                        r_state <= ST_MEASURE;
                        r_mask  <= ch_mask;
                        r_cnt   <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (ena) begin
                        r_cnt <= r_cnt + WINDOW_LOG2'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The window-end sample includes the current pwm level so all-high reads exactly 2^W.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!rst_n) begin
                r_acc[i]  <= '0;
                r_snap[i] <= '0;
            end else if (w_accept_start || w_stop_now) begin
                r_acc[i] <= '0;
            end else if (w_win_end) begin
                r_snap[i] <= w_acc_inc[i];
                r_acc[i]  <= '0;
            end else if (w_count_en) begin
                r_acc[i] <= w_acc_inc[i];
            end
        end
    end

    assign w_low = r_pend & (~r_pend + NUM_CH'(1));

    always_comb begin
        w_sel_idx = '0;
        w_sel_hit = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_sel_idx = CH_W'(i);
                w_sel_hit = 1'b1;
            end
        end
    end

    // Serializer: one record per clock, lowest pending channel first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_push_vld <= 1'b0;
            r_push_ch  <= '0;
            r_push_smp <= '0;
        end else begin
            r_push_vld <= w_sel_hit;
            if (w_sel_hit) begin
                r_push_ch  <= w_sel_idx;
                r_push_smp <= r_snap[w_sel_idx];
            end
            if (w_win_end) begin
                r_pend <= r_mask;
            end else begin
                r_pend <= r_pend & ~w_low;
            end
        end
    end

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && out_if.out_ready;
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push  = r_push_vld && (!w_full || w_pop);
    assign w_drop  = r_push_vld && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ch[r_wr_ptr]  <= r_push_ch;
            r_mem_smp[r_wr_ptr] <= r_push_smp;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A dropped record can never coincide with an accepted start, since start needs an empty serializer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_accept_start) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign out_if.out_valid  = w_valid;
    assign out_if.out_ch     = w_valid ? r_mem_ch[r_rd_ptr]  : '0;
    assign out_if.out_sample = w_valid ? r_mem_smp[r_rd_ptr] : '0;
    assign busy              = w_busy;
    assign overflow          = r_overflow;
endmodule
